// File: rtl/alu_pkg.sv
// Shared opcodes and sizing helpers for the ALU issue/writeback slice.
package alu_pkg;

    localparam int DEFAULT_DATA_WIDTH = 32;
    localparam int DEFAULT_REG_COUNT  = 8;

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_XOR  = 3'b100;
    localparam logic [2:0] OP_LAST = 3'b100;

    function automatic int reg_addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int REG_ADDR_W = reg_addr_w(DEFAULT_REG_COUNT);

endpackage

// File: rtl/alu_regfile.sv
// Operand register file: two source read ports, a debug read port,
// one synchronous write port; entry 0 always reads zero.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int REG_COUNT  = DEFAULT_REG_COUNT,
    parameter int ADDR_W     = reg_addr_w(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_W-1:0]     rs1_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [ADDR_W-1:0]     rs2_addr,
    output logic [DATA_WIDTH-1:0] rs2_data,
    input  logic [ADDR_W-1:0]     dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_WIDTH-1:0] wdata
);

    logic [DATA_WIDTH-1:0] mem [REG_COUNT];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < REG_COUNT; i++) begin
                mem[i] <= '0;
            end
        end else if (we && waddr != '0) begin
            mem[waddr] <= wdata;
        end
    end

    assign rs1_data = (rs1_addr == '0) ? '0 : mem[rs1_addr];
    assign rs2_data = (rs2_addr == '0) ? '0 : mem[rs2_addr];
    assign dbg_data = (dbg_addr == '0) ? '0 : mem[dbg_addr];

endmodule

// File: rtl/alu_issue_stage.sv
// Issue/writeback pipeline around the external combinational ALU:
// operand fetch with E->A forwarding, execute register, writeback register.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int REG_COUNT  = DEFAULT_REG_COUNT,
    parameter int ADDR_W     = reg_addr_w(REG_COUNT)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [2:0]            cmd_op,
    input  logic [ADDR_W-1:0]     cmd_rd,
    input  logic [ADDR_W-1:0]     cmd_rs1,
    input  logic [ADDR_W-1:0]     cmd_rs2,
    input  logic                  cmd_use_imm,
    input  logic [DATA_WIDTH-1:0] cmd_imm,
    output logic [DATA_WIDTH-1:0] alu_a,
    output logic [DATA_WIDTH-1:0] alu_b,
    output logic [2:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] alu_result,
    input  logic                  alu_zero,
    input  logic                  alu_overflow,
    output logic                  wb_valid,
    input  logic                  wb_ready,
    output logic [ADDR_W-1:0]     wb_rd,
    output logic [DATA_WIDTH-1:0] wb_data,
    output logic                  wb_zero,
    output logic                  wb_overflow,
    output logic                  wb_illegal,
    output logic                  ovf_sticky,
    input  logic                  ovf_clear,
    input  logic [ADDR_W-1:0]     dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    logic                  e_valid;
    logic                  e_ill;
    logic [2:0]            e_op;
    logic [ADDR_W-1:0]     e_rd;
    logic [DATA_WIDTH-1:0] e_a;
    logic [DATA_WIDTH-1:0] e_b;

    logic                  w_valid;
    logic                  w_ill;
    logic                  w_zero;
    logic                  w_ovf;
    logic [ADDR_W-1:0]     w_rd;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  ovf_q;

    logic                  e_adv;
    logic                  accept;
    logic                  w_load;
    logic                  rf_we;
    logic                  fwd_ok;
    logic [DATA_WIDTH-1:0] rf_rd1;
    logic [DATA_WIDTH-1:0] rf_rd2;
    logic [DATA_WIDTH-1:0] op_a;
    logic [DATA_WIDTH-1:0] op_b;

    assign e_adv     = !w_valid || wb_ready;
    assign cmd_ready = !rst && (!e_valid || e_adv);
    assign accept    = cmd_valid && cmd_ready;
    assign w_load    = e_valid && e_adv;
    assign rf_we     = w_load && !e_ill;
    assign fwd_ok    = e_valid && !e_ill && e_rd != '0;

    alu_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .REG_COUNT  (REG_COUNT),
        .ADDR_W     (ADDR_W)
    ) u_rf (
        .clk      (clk),
        .rst      (rst),
        .rs1_addr (cmd_rs1),
        .rs1_data (rf_rd1),
        .rs2_addr (cmd_rs2),
        .rs2_data (rf_rd2),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data),
        .we       (rf_we),
        .waddr    (e_rd),
        .wdata    (alu_result)
    );

    // The regfile already returns 0 for r0, and fwd_ok excludes e_rd == 0.
    always_comb begin
        op_a = rf_rd1;
        if (fwd_ok && e_rd == cmd_rs1) begin
            op_a = alu_result;
        end
    end

    always_comb begin
        op_b = rf_rd2;
        priority case (1'b1)
            cmd_use_imm:                op_b = cmd_imm;
            (fwd_ok && e_rd == cmd_rs2): op_b = alu_result;
            default:                    op_b = rf_rd2;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            e_valid <= 1'b0;
            e_ill   <= 1'b0;
            e_op    <= '0;
            e_rd    <= '0;
            e_a     <= '0;
            e_b     <= '0;
        end else if (accept) begin
            e_valid <= 1'b1;
            e_ill   <= (cmd_op > OP_LAST);
            e_op    <= cmd_op;
            e_rd    <= cmd_rd;
            e_a     <= op_a;
            e_b     <= op_b;
        end else if (e_adv) begin
            e_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_valid <= 1'b0;
            w_ill   <= 1'b0;
            w_zero  <= 1'b0;
            w_ovf   <= 1'b0;
            w_rd    <= '0;
            w_data  <= '0;
        end else if (w_load) begin
            w_valid <= 1'b1;
            w_ill   <= e_ill;
            w_zero  <= !e_ill && alu_zero;
            w_ovf   <= !e_ill && alu_overflow;
            w_rd    <= e_rd;
            w_data  <= e_ill ? '0 : alu_result;
        end else if (wb_ready) begin
            w_valid <= 1'b0;
        end
    end

    // A new overflow outranks a clear in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= (ovf_q && !ovf_clear) || (rf_we && alu_overflow);
        end
    end

    assign alu_a       = e_a;
    assign alu_b       = e_b;
    assign alu_op      = e_ill ? OP_ADD : e_op;
    assign wb_valid    = w_valid;
    assign wb_rd       = w_rd;
    assign wb_data     = w_data;
    assign wb_zero     = w_zero;
    assign wb_overflow = w_ovf;
    assign wb_illegal  = w_ill;
    assign ovf_sticky  = ovf_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with an architectural reference model
// and a stand-in for the downstream ALU.
module tb_alu_issue_stage;

    localparam logic [2:0] ADD = 3'd0;
    localparam logic [2:0] SUB = 3'd1;
    localparam logic [2:0] AND = 3'd2;
    localparam logic [2:0] OR  = 3'd3;
    localparam logic [2:0] XOR = 3'd4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [2:0]  cmd_op = '0;
    logic [2:0]  cmd_rd = '0;
    logic [2:0]  cmd_rs1 = '0;
    logic [2:0]  cmd_rs2 = '0;
    logic        cmd_use_imm = 1'b0;
    logic [31:0] cmd_imm = '0;
    logic [31:0] alu_a;
    logic [31:0] alu_b;
    logic [2:0]  alu_op;
    logic [31:0] alu_result;
    logic        alu_zero;
    logic        alu_overflow;
    logic        wb_valid;
    logic        wb_ready = 1'b1;
    logic [2:0]  wb_rd;
    logic [31:0] wb_data;
    logic        wb_zero;
    logic        wb_overflow;
    logic        wb_illegal;
    logic        ovf_sticky;
    logic        ovf_clear = 1'b0;
    logic [2:0]  dbg_addr = '0;
    logic [31:0] dbg_data;

    always #5 clk = ~clk;

    alu_issue_stage dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_op       (cmd_op),
        .cmd_rd       (cmd_rd),
        .cmd_rs1      (cmd_rs1),
        .cmd_rs2      (cmd_rs2),
        .cmd_use_imm  (cmd_use_imm),
        .cmd_imm      (cmd_imm),
        .alu_a        (alu_a),
        .alu_b        (alu_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_zero     (alu_zero),
        .alu_overflow (alu_overflow),
        .wb_valid     (wb_valid),
        .wb_ready     (wb_ready),
        .wb_rd        (wb_rd),
        .wb_data      (wb_data),
        .wb_zero      (wb_zero),
        .wb_overflow  (wb_overflow),
        .wb_illegal   (wb_illegal),
        .ovf_sticky   (ovf_sticky),
        .ovf_clear    (ovf_clear),
        .dbg_addr     (dbg_addr),
        .dbg_data     (dbg_data)
    );

    // Downstream ALU stand-in
    always_comb begin
        alu_result   = '0;
        alu_overflow = 1'b0;
        case (alu_op)
            ADD: begin
                alu_result   = alu_a + alu_b;
                alu_overflow = (alu_a[31] == alu_b[31]) &&
                               (alu_result[31] != alu_a[31]);
            end
            SUB: begin
                alu_result   = alu_a - alu_b;
                alu_overflow = (alu_a[31] != alu_b[31]) &&
                               (alu_result[31] != alu_a[31]);
            end
            AND: alu_result = alu_a & alu_b;
            OR:  alu_result = alu_a | alu_b;
            XOR: alu_result = alu_a ^ alu_b;
            default: alu_result = '0;
        endcase
        alu_zero = (alu_result == '0);
    end

    typedef struct {
        logic [2:0]  rd;
        logic [31:0] data;
        logic        zero;
        logic        ovf;
        logic        ill;
    } wb_t;

    typedef struct {
        logic [2:0]  op;
        logic [2:0]  rd;
        logic [2:0]  rs1;
        logic [2:0]  rs2;
        logic        ui;
        logic [31:0] imm;
    } cmd_t;

    wb_t         exp_q[$];
    logic [31:0] rf_m [8];
    int          n_checks = 0;
    int          n_fail = 0;

    function void chk(string name, logic [63:0] act, logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endfunction

    // Architectural semantics: commands execute in program order.
    function automatic wb_t model_exec(cmd_t c);
        wb_t         r;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] s;
        a = (c.rs1 == 0) ? 32'd0 : rf_m[c.rs1];
        b = c.ui ? c.imm : ((c.rs2 == 0) ? 32'd0 : rf_m[c.rs2]);
        r.rd = c.rd;
        r.ill = (c.op > 3'd4);
        r.ovf = 1'b0;
        s = 32'd0;
        if (c.op == ADD) begin
            s = a + b;
            r.ovf = (a[31] == b[31]) && (s[31] != a[31]);
        end else if (c.op == SUB) begin
            s = a - b;
            r.ovf = (a[31] != b[31]) && (s[31] != a[31]);
        end else if (c.op == AND) s = a & b;
        else if (c.op == OR) s = a | b;
        else if (c.op == XOR) s = a ^ b;
        r.data = s;
        r.zero = !r.ill && (s == 0);
        if (!r.ill && c.rd != 0) rf_m[c.rd] = s;
        return r;
    endfunction

    logic [40:0] held;
    logic        hold = 1'b0;

    always @(negedge clk) begin
        wb_t  e;
        cmd_t c;
        if (rst) begin
            exp_q.delete();
            for (int i = 0; i < 8; i++) rf_m[i] = '0;
            hold = 1'b0;
        end else begin
            if (hold) begin
                chk("w_hold_stable",
                    {wb_valid, wb_rd, wb_data, wb_zero, wb_overflow, wb_illegal},
                    held);
            end
            if (wb_valid && wb_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL wb_unexpected: got rd %0d data %h, expected none",
                             wb_rd, wb_data);
                end else begin
                    e = exp_q.pop_front();
                    chk("wb_rd", wb_rd, e.rd);
                    chk("wb_data", wb_data, e.data);
                    chk("wb_zero", wb_zero, e.zero);
                    chk("wb_overflow", wb_overflow, e.ovf);
                    chk("wb_illegal", wb_illegal, e.ill);
                end
            end
            hold = wb_valid && !wb_ready;
            held = {wb_valid, wb_rd, wb_data, wb_zero, wb_overflow, wb_illegal};
            if (cmd_valid && cmd_ready) begin
                c.op = cmd_op;
                c.rd = cmd_rd;
                c.rs1 = cmd_rs1;
                c.rs2 = cmd_rs2;
                c.ui = cmd_use_imm;
                c.imm = cmd_imm;
                exp_q.push_back(model_exec(c));
            end
        end
    end

    task automatic drive(cmd_t c);
        cmd_op = c.op;
        cmd_rd = c.rd;
        cmd_rs1 = c.rs1;
        cmd_rs2 = c.rs2;
        cmd_use_imm = c.ui;
        cmd_imm = c.imm;
    endtask

    // Called at posedge+1; returns at posedge+1 right after the accept edge.
    task automatic issue(logic [2:0] op, logic [2:0] rd, logic [2:0] rs1,
                         logic [2:0] rs2, logic ui, logic [31:0] imm);
        cmd_t c;
        int   t;
        c = '{op, rd, rs1, rs2, ui, imm};
        drive(c);
        cmd_valid = 1'b1;
        t = 0;
        do begin
            @(negedge clk);
            t++;
        end while (!cmd_ready && t < 50);
        if (!cmd_ready) begin
            n_checks++;
            n_fail++;
            $display("FAIL issue_timeout: got cmd_ready 0, expected 1");
        end
        @(posedge clk);
        #1 cmd_valid = 1'b0;
    endtask

    task automatic dbg_chk(string name, logic [2:0] a, logic [31:0] exp);
        dbg_addr = a;
        #1 chk(name, dbg_data, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        cmd_t        cl[4];
        int          idx;
        int          t;
        logic        fire;
        logic [31:0] a_s;
        logic [31:0] b_s;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_wb_valid", wb_valid, 0);
        chk("rst_cmd_ready", cmd_ready, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_alu_b", alu_b, 0);
        chk("rst_wb_data", wb_data, 0);
        chk("rst_ovf", ovf_sticky, 0);
        @(posedge clk);
        #1 rst = 1'b0;

        issue(ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'd5);
        @(negedge clk);
        chk("lat_e_wb_valid", wb_valid, 0);
        chk("lat_alu_b", alu_b, 32'd5);
        @(negedge clk);
        chk("lat_wb_valid", wb_valid, 1);
        chk("addi_data", wb_data, 32'd5);
        chk("addi_zero", wb_zero, 0);
        dbg_chk("addi_rf_r1", 3'd1, 32'd5);
        @(posedge clk);
        #1;

        issue(ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'h7FFF_FFFF);
        issue(ADD, 3'd2, 3'd1, 3'd1, 1'b0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("fwd_add_data", wb_data, 32'hFFFF_FFFE);
        chk("fwd_add_ovf", wb_overflow, 1);
        chk("fwd_add_sticky", ovf_sticky, 1);
        @(posedge clk);
        #1;
        issue(ADD, 3'd4, 3'd1, 3'd1, 1'b0, 32'd0);
        ovf_clear = 1'b1;
        @(posedge clk);
        #1 ovf_clear = 1'b0;
        @(negedge clk);
        chk("clr_vs_set_ovf", wb_overflow, 1);
        chk("clr_vs_set_sticky", ovf_sticky, 1);
        @(posedge clk);
        #1 ovf_clear = 1'b1;
        @(posedge clk);
        #1 ovf_clear = 1'b0;
        @(negedge clk);
        chk("clear_sticky", ovf_sticky, 0);
        @(posedge clk);
        #1;

        issue(SUB, 3'd3, 3'd1, 3'd1, 1'b0, 32'd0);
        @(negedge clk);
        @(negedge clk);
        chk("sub_data", wb_data, 0);
        chk("sub_zero", wb_zero, 1);
        @(posedge clk);
        #1;
        issue(ADD, 3'd5, 3'd0, 3'd0, 1'b1, 32'hF0F0_F0F0);
        issue(XOR, 3'd6, 3'd5, 3'd0, 1'b1, 32'h0FF0_0FF0);
        issue(AND, 3'd7, 3'd5, 3'd0, 1'b1, 32'h0FF0_0FF0);
        issue(OR,  3'd4, 3'd6, 3'd7, 1'b0, 32'd0);
        repeat (3) @(posedge clk);
        #1;
        dbg_chk("rf_r1", 3'd1, 32'h7FFF_FFFF);
        dbg_chk("rf_r2", 3'd2, 32'hFFFF_FFFE);
        dbg_chk("rf_r5", 3'd5, 32'hF0F0_F0F0);
        dbg_chk("rf_xor_r6", 3'd6, 32'hFF00_FF00);
        dbg_chk("rf_and_r7", 3'd7, 32'h00F0_00F0);
        dbg_chk("rf_or_r4", 3'd4, 32'hFFF0_FFF0);
        @(posedge clk);
        #1;

        issue(3'b110, 3'd6, 3'd5, 3'd6, 1'b0, 32'd0);
        issue(ADD, 3'd7, 3'd6, 3'd0, 1'b0, 32'd0);
        @(negedge clk);
        chk("ill_flag", wb_illegal, 1);
        chk("ill_data", wb_data, 0);
        chk("ill_zero", wb_zero, 0);
        @(negedge clk);
        chk("post_ill_fwd", wb_data, 32'hFF00_FF00);
        @(posedge clk);
        #1;
        issue(ADD, 3'd0, 3'd0, 3'd0, 1'b1, 32'd123);
        repeat (3) @(posedge clk);
        #1;
        dbg_chk("ill_rd_kept", 3'd6, 32'hFF00_FF00);
        dbg_chk("r0_zero", 3'd0, 32'd0);
        @(posedge clk);
        #1;

        cl[0] = '{ADD, 3'd1, 3'd0, 3'd0, 1'b1, 32'd1};
        cl[1] = '{ADD, 3'd2, 3'd1, 3'd1, 1'b0, 32'd0};
        cl[2] = '{ADD, 3'd3, 3'd2, 3'd0, 1'b1, 32'd10};
        cl[3] = '{ADD, 3'd4, 3'd3, 3'd2, 1'b0, 32'd0};
        wb_ready = 1'b0;
        idx = 0;
        drive(cl[0]);
        cmd_valid = 1'b1;
        a_s = '0;
        b_s = '0;
        for (int cyc = 0; cyc < 5; cyc++) begin
            @(negedge clk);
            fire = cmd_valid && cmd_ready;
            if (cyc == 3) begin
                a_s = alu_a;
                b_s = alu_b;
            end
            if (cyc == 4) begin
                chk("stall_cmd_ready", cmd_ready, 0);
                chk("stall_wb_valid", wb_valid, 1);
                chk("stall_alu_a", alu_a, a_s);
                chk("stall_alu_b", alu_b, b_s);
            end
            @(posedge clk);
            #1;
            if (fire) begin
                idx++;
                if (idx < 4) drive(cl[idx]);
                else cmd_valid = 1'b0;
            end
        end
        chk("stall_accepted", idx, 2);
        wb_ready = 1'b1;
        t = 0;
        while (idx < 4 && t < 20) begin
            @(negedge clk);
            fire = cmd_valid && cmd_ready;
            @(posedge clk);
            #1;
            t++;
            if (fire) begin
                idx++;
                if (idx < 4) drive(cl[idx]);
                else cmd_valid = 1'b0;
            end
        end
        cmd_valid = 1'b0;
        chk("release_accepted", idx, 4);
        repeat (4) @(posedge clk);
        #1;
        dbg_chk("stall_r4", 3'd4, 32'd14);
        chk("stall_drained", exp_q.size(), 0);
        @(posedge clk);
        #1;

        wb_ready = 1'b0;
        issue(ADD, 3'd5, 3'd1, 3'd0, 1'b1, 32'h7FFF_FFFF);
        issue(ADD, 3'd6, 3'd0, 3'd0, 1'b1, 32'd88);
        @(negedge clk);
        chk("pre_rst_wb_valid", wb_valid, 1);
        chk("pre_rst_sticky", ovf_sticky, 1);
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_wb_valid", wb_valid, 0);
        chk("mid_rst_cmd_ready", cmd_ready, 0);
        chk("mid_rst_alu_a", alu_a, 0);
        chk("mid_rst_alu_b", alu_b, 0);
        chk("mid_rst_wb_data", wb_data, 0);
        chk("mid_rst_wb_ovf", wb_overflow, 0);
        chk("mid_rst_sticky", ovf_sticky, 0);
        for (int i = 0; i < 8; i++) begin
            dbg_chk("mid_rst_rf", 3'(i), 32'd0);
        end
        @(posedge clk);
        #1 rst = 1'b0;
        wb_ready = 1'b1;
        repeat (6) begin
            @(negedge clk);
            chk("post_rst_no_wb", wb_valid, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
